// File: rtl/mux_pkg.sv
// Shared constants for the registered operand multiplexer: default width,
// legal parameter limits and the select encodings.
package mux_pkg;
  localparam int MUX_DEFAULT_WIDTH = 8;
  localparam int MUX_MAX_WIDTH     = 64;
  localparam int MUX_MAX_STAGES    = 4;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
endpackage

// File: rtl/mux_stage.sv
// One pipeline register of the operand multiplexer: WIDTH bits,
// loads every edge, cleared asynchronously by an active-high reset.
module mux_stage
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/reg_mux2.sv
// Registered 2-to-1 operand select: combinational pick of A or B, then a
// chain of STAGES clear-on-reset registers; Result comes straight off the last one.
module reg_mux2
  import mux_pkg::*;
#(
  parameter int WIDTH  = MUX_DEFAULT_WIDTH,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sel,
  output logic [WIDTH-1:0] Result
);

  if (WIDTH < 1 || WIDTH > MUX_MAX_WIDTH) begin : g_bad_width
    $error("reg_mux2: WIDTH=%0d outside 1..%0d", WIDTH, MUX_MAX_WIDTH);
  end
  if (STAGES < 1 || STAGES > MUX_MAX_STAGES) begin : g_bad_stages
    $error("reg_mux2: STAGES=%0d outside 1..%0d", STAGES, MUX_MAX_STAGES);
  end

  logic [WIDTH-1:0] mux_d;

  always_comb begin
    mux_d = A;
    case (Sel)
      SEL_A:   mux_d = A;
      SEL_B:   mux_d = B;
      default: mux_d = A;
    endcase
  end

  // chain[0] is the combinational select; chain[k] is the output of stage k.
  logic [WIDTH-1:0] chain [STAGES+1];

  assign chain[0] = mux_d;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    mux_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk_i(clk),
      .rst_i(reset),
      .d_i  (chain[k]),
      .q_o  (chain[k+1])
    );
  end

  assign Result = chain[STAGES];

endmodule

// File: tb/tb_reg_mux2.sv
// Directed bench for reg_mux2: default 8-bit/1-stage, 8-bit/3-stage, and
// 1-bit / 64-bit width corners, all on one clock.
module tb_reg_mux2;

  logic clk;

  // default configuration
  logic       rst_a;
  logic [7:0] a_a, b_a, res_a;
  logic       sel_a;

  // three-stage pipeline
  logic       rst_p;
  logic [7:0] a_p, b_p, res_p;
  logic       sel_p;

  // width corners share reset and select
  logic        rst_w, sel_w;
  logic [0:0]  a_1, b_1, res_1;
  logic [63:0] a_64, b_64, res_64;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  reg_mux2 u_dut_a (
    .clk(clk), .reset(rst_a), .A(a_a), .B(b_a), .Sel(sel_a), .Result(res_a)
  );

  reg_mux2 #(.WIDTH(8), .STAGES(3)) u_dut_p (
    .clk(clk), .reset(rst_p), .A(a_p), .B(b_p), .Sel(sel_p), .Result(res_p)
  );

  reg_mux2 #(.WIDTH(1), .STAGES(1)) u_dut_1 (
    .clk(clk), .reset(rst_w), .A(a_1), .B(b_1), .Sel(sel_w), .Result(res_1)
  );

  reg_mux2 #(.WIDTH(64), .STAGES(1)) u_dut_64 (
    .clk(clk), .reset(rst_w), .A(a_64), .B(b_64), .Sel(sel_w), .Result(res_64)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // one rising edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b1; a_a = 8'h55; b_a = 8'hAA; sel_a = 1'b1;
    rst_p = 1'b1; a_p = 8'h00; b_p = 8'h00; sel_p = 1'b0;
    rst_w = 1'b1; sel_w = 1'b0;
    a_1 = 1'b1; b_1 = 1'b0; a_64 = '1; b_64 = '0;
    #1;

    // reset without clocking, then held across edges
    check_vec("rst_async", 64'(res_a), 64'h00);
    check_vec("rst_async_p", 64'(res_p), 64'h00);
    check_vec("rst_async_w64", res_64, 64'h0);
    tick();
    check_vec("rst_hold_1", 64'(res_a), 64'h00);
    tick();
    check_vec("rst_hold_2", 64'(res_a), 64'h00);

    // select B
    rst_a = 1'b0;
    a_a = 8'h00; b_a = 8'h73; sel_a = 1'b1;
    tick();
    check_vec("selb_73", 64'(res_a), 64'h73);
    a_a = 8'h08; b_a = 8'h77;
    tick();
    check_vec("selb_77", 64'(res_a), 64'h77);
    a_a = 8'h01; b_a = 8'h7E;
    tick();
    check_vec("selb_7e", 64'(res_a), 64'h7E);

    // select A, then unselected operand changes
    a_a = 8'h08; b_a = 8'h77; sel_a = 1'b0;
    tick();
    check_vec("sela_08", 64'(res_a), 64'h08);
    b_a = 8'hFF;
    tick();
    check_vec("sela_bchg", 64'(res_a), 64'h08);

    // changes between edges must not reach Result
    sel_a = 1'b1; a_a = 8'hC3;
    #2;
    check_vec("no_comb_path", 64'(res_a), 64'h08);

    // back-to-back toggle
    a_a = 8'h0F; b_a = 8'hF0;
    for (int i = 0; i < 6; i++) begin
      sel_a = i[0];
      tick();
      check_vec($sformatf("toggle_%0d", i), 64'(res_a),
                i[0] ? 64'hF0 : 64'h0F);
    end

    // three-stage pipeline: latency, mid-stream reset
    rst_p = 1'b0; sel_p = 1'b0;
    a_p = 8'h11; tick(); check_vec("p3_lat_1", 64'(res_p), 64'h00);
    a_p = 8'h22; tick(); check_vec("p3_lat_2", 64'(res_p), 64'h00);
    a_p = 8'h33; tick(); check_vec("p3_lat_3", 64'(res_p), 64'h11);
    rst_p = 1'b1;
    #1;
    check_vec("p3_rst_now", 64'(res_p), 64'h00);
    rst_p = 1'b0;
    a_p = 8'h44; tick(); check_vec("p3_post_1", 64'(res_p), 64'h00);
    a_p = 8'h55; tick(); check_vec("p3_post_2", 64'(res_p), 64'h00);
    a_p = 8'h66; tick(); check_vec("p3_post_3", 64'(res_p), 64'h44);
    sel_p = 1'b1; b_p = 8'h99; a_p = 8'h77;
    tick(); check_vec("p3_tput_55", 64'(res_p), 64'h55);
    tick(); check_vec("p3_tput_66", 64'(res_p), 64'h66);
    tick(); check_vec("p3_selb_99", 64'(res_p), 64'h99);

    // width corners
    rst_w = 1'b0; sel_w = 1'b0;
    tick();
    check_vec("w1_ones", 64'(res_1), 64'h1);
    check_vec("w64_ones", res_64, 64'hFFFF_FFFF_FFFF_FFFF);
    sel_w = 1'b1;
    tick();
    check_vec("w1_zero", 64'(res_1), 64'h0);
    check_vec("w64_zero", res_64, 64'h0);
    sel_w = 1'b0;
    tick();
    check_vec("w64_ones_again", res_64, 64'hFFFF_FFFF_FFFF_FFFF);
    rst_w = 1'b1;
    #1;
    check_vec("w64_rst_now", res_64, 64'h0);
    check_vec("w1_rst_now", 64'(res_1), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
